// File: rtl/div_if.sv
// div_if: start/done request bus between the core and the divide unit.
interface div_if #(parameter int XLEN = 32);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [2:0]      status_reg;
    modport master(output start, op, a, b, input busy, done, result, status_reg);
    modport slave(input start, op, a, b, output busy, done, result, status_reg);
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative restoring DIV/DIVU/REM/REMU, one quotient bit per cycle.
// status_reg layout matches the ALU flags: {exception, sign, zero}.
module div_unit #(parameter int XLEN = 32) (
    input logic clk,
    input logic rst,
    div_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0, S_DIV = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    logic [1:0] state;
    logic [1:0] op_q;
    logic sa, sb;
    logic [XLEN-1:0] quo, rem, dvs, res_q;
    logic [4:0] cnt;
    logic [2:0] st_q;
    logic sgn, in_sgn, bz, ovf, nb;
    logic [XLEN:0] sh;
    logic [XLEN+1:0] diff;
    logic [XLEN-1:0] qf, rf, fix_res, sp_res;
    always_comb begin
        sgn = ~op_q[0];
        sh = {rem, quo[XLEN-1]};
        diff = {1'b0, sh} - {2'b0, dvs};
        nb = ~diff[XLEN+1];
        qf = (sgn & (sa ^ sb)) ? -quo : quo;
        rf = (sgn & sa) ? -rem : rem;
        fix_res = op_q[1] ? rf : qf;
        in_sgn = ~bus.op[0];
        bz = bus.b == '0;
        ovf = in_sgn & (bus.a == MIN_NEG) & (&bus.b);
        // Divide-by-zero takes priority over overflow (b=0 can never be -1 anyway)
        sp_res = bz ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : MIN_NEG);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_q <= '0;
            sa <= 1'b0;
            sb <= 1'b0;
            quo <= '0;
            rem <= '0;
            dvs <= '0;
            cnt <= '0;
            res_q <= '0;
            st_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    op_q <= bus.op;
                    sa <= bus.a[XLEN-1];
                    sb <= bus.b[XLEN-1];
                    quo <= (in_sgn & bus.a[XLEN-1]) ? -bus.a : bus.a;
                    dvs <= (in_sgn & bus.b[XLEN-1]) ? -bus.b : bus.b;
                    rem <= '0;
                    cnt <= '0;
                    if (bz | ovf) begin
                        res_q <= sp_res;
                        st_q <= {1'b1, sp_res[XLEN-1], sp_res == '0};
                        state <= S_DONE;
                    end else begin
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem <= nb ? diff[XLEN-1:0] : sh[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], nb};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= S_FIX;
                end
                S_FIX: begin
                    res_q <= fix_res;
                    st_q <= {1'b0, fix_res[XLEN-1], fix_res == '0};
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    assign bus.busy = state != S_IDLE;
    assign bus.done = state == S_DONE;
    assign bus.result = res_q;
    assign bus.status_reg = st_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table, robustness sequences and randomized ops vs an arithmetic model.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    div_if #(.XLEN(32)) bus();
    div_unit #(.XLEN(32)) dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  st;
        int          lat;
    } vec_t;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [2:0] st);
        longint x, y, q, m;
        logic exc;
        if (op[0]) begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end else begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end
        exc = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        if (b == 0) begin
            q = -1;
            m = x;
        end else begin
            q = x / y;
            m = x % y;
        end
        r = op[1] ? m[31:0] : q[31:0];
        st = {exc, r[31], r == 32'd0};
    endfunction

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [2:0] st, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op = 2'($urandom_range(3));
        bus.a = $urandom;
        bus.b = $urandom;
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = bus.result;
        st = bus.status_reg;
        @(posedge clk);
        #1;
        check("done_pulse", {31'b0, bus.done}, 32'd0);
        check("idle_after", {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] r, er;
        logic [2:0] st, est;
        int lat, dn, de;
        logic [1:0] op;
        logic [31:0] a, b;
        tbl[0]  = '{2'b01, 32'd100, 32'd7, 32'd14, 3'b000, 33};
        tbl[1]  = '{2'b11, 32'd100, 32'd7, 32'd2, 3'b000, 33};
        tbl[2]  = '{2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 3'b010, 33};
        tbl[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 3'b010, 33};
        tbl[4]  = '{2'b01, 32'd3, 32'd5, 32'd0, 3'b001, 33};
        tbl[5]  = '{2'b11, 32'd3, 32'd5, 32'd3, 3'b000, 33};
        tbl[6]  = '{2'b00, 32'd42, 32'd0, 32'hFFFF_FFFF, 3'b110, 0};
        tbl[7]  = '{2'b10, 32'd42, 32'd0, 32'd42, 3'b100, 0};
        tbl[8]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3'b110, 0};
        tbl[9]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 3'b101, 0};
        tbl[10] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 3'b001, 33};
        tbl[11] = '{2'b11, 32'd0, 32'd0, 32'd0, 3'b101, 0};
        tbl[12] = '{2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 3'b010, 33};
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_status", {29'b0, bus.status_reg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run(tbl[i].op, tbl[i].a, tbl[i].b, r, st, lat);
            check($sformatf("vec%0d_result", i), r, tbl[i].res);
            check($sformatf("vec%0d_status", i), {29'b0, st}, {29'b0, tbl[i].st});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
        end

        // Starts during DIV and DONE must be dropped, not queued
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'b01;
        bus.a = 32'd100;
        bus.b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dn = 0;
        de = -1;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            bus.start = (e == 5 || e == 34);
            bus.op = 2'b01;
            bus.a = $urandom;
            bus.b = 32'd1;
            @(posedge clk);
            #1;
            if (bus.done) begin
                dn++;
                de = e;
            end
        end
        bus.start = 1'b0;
        check("ign_done_count", 32'(dn), 32'd1);
        check("ign_done_edge", 32'(de), 32'd33);
        check("ign_result", bus.result, 32'd14);
        check("ign_status", {29'b0, bus.status_reg}, 32'd0);
        check("ign_busy", {31'b0, bus.busy}, 32'd0);

        // Reset mid-operation at edge k+10
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'b01;
        bus.a = 32'd100;
        bus.b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        check("midrst_done", {31'b0, bus.done}, 32'd0);
        check("midrst_result", bus.result, 32'd0);
        check("midrst_status", {29'b0, bus.status_reg}, 32'd0);
        dn = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dn++;
        end
        check("midrst_quiet", 32'(dn), 32'd0);
        run(2'b01, 32'd9, 32'd3, r, st, lat);
        check("fresh_result", r, 32'd3);
        check("fresh_latency", 32'(lat), 32'd33);

        // Reset and start on the same edge: reset wins
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.a = 32'd5;
        bus.b = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.start = 1'b0;
        check("rststart_busy", {31'b0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        check("rststart_done", {31'b0, bus.done}, 32'd0);
        check("rststart_idle", {31'b0, bus.busy}, 32'd0);

        for (int i = 0; i < 200; i++) begin
            op = 2'($urandom_range(3));
            a = $urandom;
            case ($urandom_range(7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(15));
                default: b = $urandom >> $urandom_range(31);
            endcase
            if ($urandom_range(15) == 0) a = 32'h8000_0000;
            model(op, a, b, er, est);
            run(op, a, b, r, st, lat);
            check($sformatf("rnd%0d_result op=%0d a=%h b=%h", i, op, a, b), r, er);
            check($sformatf("rnd%0d_status", i), {29'b0, st}, {29'b0, est});
            check($sformatf("rnd%0d_latency", i), 32'(lat), est[2] ? 32'd0 : 32'd33);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
